// File: rtl/ts_ctrl_pkg.sv
// rtl/ts_ctrl_pkg.sv - state encodings, command opcodes and default widths for the timestamp run controller
package ts_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_RUNNING   = 3'd3,
    ST_DONE      = 3'd4
  } ts_state_t;

  localparam logic [1:0] OP_ARM   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_ABORT = 2'd3;

  localparam int DEF_DUR_W        = 32;
  localparam int DEF_TS_W         = 64;
  localparam int DEF_TRIG_TIMEOUT = 1000000;

endpackage

// File: rtl/ts_duration_counter.sv
// rtl/ts_duration_counter.sv - load/enable saturating cycle counter with expiry flag
module ts_duration_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

  // Flags the last enabled cycle of a limit-length window; limit 0 never expires.
  assign expired = en && (limit != '0) && (count == limit - ONE);

endmodule

// File: rtl/timestamp_run_controller.sv
// rtl/timestamp_run_controller.sv - clear/arm/start/run/stop sequencer for the 64-bit timestamp generator
// Optional WAIT_TRIG timeout enabled by defining TS_RUN_CTRL_TRIG_TIMEOUT_EN.
module timestamp_run_controller
  import ts_ctrl_pkg::*;
#(
  parameter int DUR_W        = DEF_DUR_W,
  parameter int TS_W         = DEF_TS_W,
  parameter int TRIG_TIMEOUT = DEF_TRIG_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DUR_W-1:0] cfg_duration,
  input  logic             cfg_use_trigger,
  input  logic             trigger_in,
  input  logic [TS_W-1:0]  timestamp_in,
  output logic             ts_run,
  output logic             ts_clear,
  output logic [TS_W-1:0]  stop_timestamp,
  output logic             done,
  output logic             cmd_err,
  output logic [2:0]       state_o,
  output logic             timeout_err
);

  ts_state_t        state, nxt_state;
  logic [DUR_W-1:0] dur_q;
  logic             cmd_fire;
  logic             run_expired;
  logic             nxt_clear, nxt_err;

  assign cmd_ready = (state != ST_DONE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign state_o   = state;

  ts_duration_counter #(.W(DUR_W)) u_run_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (state != ST_RUNNING),
    .en      (state == ST_RUNNING),
    .limit   (dur_q),
    .expired (run_expired)
  );

`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
  localparam logic [DUR_W-1:0] TMO_LIMIT = DUR_W'(TRIG_TIMEOUT);

  logic tmo_expired, nxt_tmo, tmo_q;

  ts_duration_counter #(.W(DUR_W)) u_tmo_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (state != ST_WAIT_TRIG),
    .en      (state == ST_WAIT_TRIG),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_clear = 1'b0;
    nxt_err   = 1'b0;
`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
    nxt_tmo   = 1'b0;
`endif
    if (cmd_fire && (cmd_op == OP_ABORT)) begin
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_op == OP_ARM) begin
              nxt_state = ST_ARMED;
              nxt_clear = 1'b1;
            end else begin
              nxt_err = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_ARM:   nxt_clear = 1'b1;
              OP_START: nxt_state = cfg_use_trigger ? ST_WAIT_TRIG : ST_RUNNING;
              default:  nxt_err   = 1'b1;
            endcase
          end
        end
        ST_WAIT_TRIG: begin
          nxt_err = cmd_fire;
          // A STOP here is rejected and also holds off a coincident trigger.
          if (!(cmd_fire && (cmd_op == OP_STOP))) begin
            if (trigger_in) begin
              nxt_state = ST_RUNNING;
`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
            end else if (tmo_expired) begin
              nxt_state = ST_IDLE;
              nxt_tmo   = 1'b1;
`endif
            end
          end
        end
        ST_RUNNING: begin
          if (cmd_fire && (cmd_op == OP_STOP)) begin
            nxt_state = ST_DONE;
          end else begin
            nxt_err = cmd_fire;
            if (run_expired) begin
              nxt_state = ST_DONE;
            end
          end
        end
        ST_DONE: nxt_state = ST_IDLE;
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ts_run         <= 1'b0;
      ts_clear       <= 1'b0;
      done           <= 1'b0;
      cmd_err        <= 1'b0;
      stop_timestamp <= '0;
      dur_q          <= '0;
`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
      tmo_q          <= 1'b0;
`endif
    end else begin
      state    <= nxt_state;
      ts_run   <= (nxt_state == ST_RUNNING);
      ts_clear <= nxt_clear;
      cmd_err  <= nxt_err;
      // Generator lags ts_run by one cycle, so its value in DONE is the final count.
      done     <= (state == ST_DONE);
      if (state == ST_DONE) begin
        stop_timestamp <= timestamp_in;
      end
      if ((state == ST_ARMED) && cmd_fire && (cmd_op == OP_START)) begin
        dur_q <= cfg_duration;
      end
`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
      tmo_q <= nxt_tmo;
`endif
    end
  end

endmodule

// File: tb/tb_timestamp_run_controller.sv
// tb/tb_timestamp_run_controller.sv - self-checking bench for timestamp_run_controller
module tb_timestamp_run_controller;
  import ts_ctrl_pkg::*;

`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
  localparam int TB_TO = 100;
`else
  localparam int TB_TO = 1000000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cfg_duration;
  logic        cfg_use_trigger;
  logic        trigger_in;
  logic [63:0] timestamp_in;
  logic        ts_run;
  logic        ts_clear;
  logic [63:0] stop_timestamp;
  logic        done;
  logic        cmd_err;
  logic [2:0]  state_o;
  logic        timeout_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] prev_ts  = 64'd0;

  always #5 clk = ~clk;

  timestamp_run_controller #(
    .DUR_W(32), .TS_W(64), .TRIG_TIMEOUT(TB_TO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cfg_duration(cfg_duration), .cfg_use_trigger(cfg_use_trigger),
    .trigger_in(trigger_in), .timestamp_in(timestamp_in), .ts_run(ts_run),
    .ts_clear(ts_clear), .stop_timestamp(stop_timestamp), .done(done),
    .cmd_err(cmd_err), .state_o(state_o), .timeout_err(timeout_err)
  );

  // Generator stand-in: one-cycle latency counter cleared by ts_clear.
  always @(posedge clk) begin
    if (reset || ts_clear) timestamp_in <= 64'd0;
    else if (ts_run)       timestamp_in <= timestamp_in + 64'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int dur; bit trig; int tdly; int stop_at; int abort_at; int exp_run; bit exp_done;
  } vec_t;

  task automatic run_and_check(input string tag, input int dur, input bit trig, input int tdly,
                               input int stop_at, input int abort_at,
                               input int exp_run, input bit exp_done);
    int runs = 0, dones = 0, clrs = 0, errs = 0, tmos = 0, lag = -1, waited = 0, trig_at = -1;
    bit fin = 0;
    logic [63:0] exp_ts;
    cmd_valid = 1'b1; cmd_op = OP_ARM;
    @(negedge clk);
    if (ts_clear) clrs++;
    cmd_op = OP_START; cfg_duration = dur; cfg_use_trigger = trig;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ts_clear) clrs++;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (ts_run) runs++;
      if (done) dones++;
      if (cmd_err) errs++;
      if (timeout_err) tmos++;
      if (ts_clear) clrs++;
      if (state_o == ST_DONE) check({tag, " ready_in_done"}, {63'd0, cmd_ready}, 64'd0);
      if (trigger_in && ts_run) begin trigger_in = 1'b0; lag = cyc - trig_at; end
      if (trig && trig_at < 0) begin
        if (waited == tdly) begin trigger_in = 1'b1; trig_at = cyc; end
        waited++;
      end
      cmd_valid = 1'b0;
      if (ts_run && stop_at != 0 && runs == stop_at) begin cmd_valid = 1'b1; cmd_op = OP_STOP; end
      if (ts_run && abort_at != 0 && runs == abort_at) begin cmd_valid = 1'b1; cmd_op = OP_ABORT; end
      if (state_o == ST_IDLE) fin = 1;
      else @(negedge clk);
    end
    if (!fin) check({tag, " run_bound"}, 64'd0, 64'd1);
    cmd_valid = 1'b0; trigger_in = 1'b0;
    @(negedge clk);
    if (done) dones++;
    if (cmd_err) errs++;
    exp_ts  = exp_done ? 64'(exp_run) : prev_ts;
    prev_ts = exp_ts;
    check({tag, " run_cycles"}, 64'(runs), 64'(exp_run));
    check({tag, " done_pulses"}, 64'(dones), exp_done ? 64'd1 : 64'd0);
    check({tag, " stop_timestamp"}, stop_timestamp, exp_ts);
    check({tag, " clear_pulses"}, 64'(clrs), 64'd1);
    check({tag, " cmd_err"}, 64'(errs), 64'd0);
    check({tag, " timeout_err"}, 64'(tmos), 64'd0);
    if (trig) check({tag, " trig_lag"}, 64'(lag), 64'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int d, s, a, r0, r;
    bit t, dn;

    vecs[0] = '{50, 0,  0,  0, 0, 50, 1};
    vecs[1] = '{10, 1, 20,  0, 0, 10, 1};
    vecs[2] = '{ 0, 0,  0, 37, 0, 37, 1};
    vecs[3] = '{50, 0,  0,  0, 5,  5, 0};
    vecs[4] = '{ 8, 0,  0,  8, 0,  8, 1};
    vecs[5] = '{ 1, 0,  0,  0, 0,  1, 1};
    vecs[6] = '{ 3, 1,  0,  0, 0,  3, 1};
    vecs[7] = '{20, 0,  0, 30, 0, 20, 1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_ARM; cfg_duration = '0;
    cfg_use_trigger = 1'b0; trigger_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst state", 64'(state_o), 64'd0);
    check("rst ts_run", {63'd0, ts_run}, 64'd0);
    check("rst ts_clear", {63'd0, ts_clear}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst cmd_err", {63'd0, cmd_err}, 64'd0);
    check("rst timeout_err", {63'd0, timeout_err}, 64'd0);
    check("rst stop_ts", stop_timestamp, 64'd0);
    check("rst cmd_ready", {63'd0, cmd_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // START and STOP while IDLE are rejected.
    cmd_valid = 1'b1; cmd_op = OP_START;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("idle start err", {63'd0, cmd_err}, 64'd1);
    check("idle start state", 64'(state_o), 64'd0);
    @(negedge clk);
    check("idle err single", {63'd0, cmd_err}, 64'd0);

    // STOP while ARMED is rejected, ABORT returns to IDLE.
    cmd_valid = 1'b1; cmd_op = OP_ARM;
    @(negedge clk);
    cmd_op = OP_STOP;
    @(negedge clk);
    cmd_op = OP_ABORT;
    check("armed stop err", {63'd0, cmd_err}, 64'd1);
    check("armed stop state", 64'(state_o), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("armed abort state", 64'(state_o), 64'd0);
    @(negedge clk);

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].dur, vecs[i].trig, vecs[i].tdly,
                    vecs[i].stop_at, vecs[i].abort_at, vecs[i].exp_run, vecs[i].exp_done);

    // Randomized runs against the window-length rules.
    for (int k = 0; k < 12; k++) begin
      d = $urandom_range(0, 40);
      s = (d == 0) ? $urandom_range(1, 40) : (($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : 0);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
      t = 1'($urandom_range(0, 1));
      if (d == 0)                 r0 = s;
      else if (s != 0 && s < d)   r0 = s;
      else                        r0 = d;
      if (a != 0 && a <= r0) begin r = a; dn = 1'b0; end
      else begin r = r0; dn = 1'b1; end
      run_and_check($sformatf("rnd%0d", k), d, t, $urandom_range(0, 15), s, a, r, dn);
    end

`ifdef TS_RUN_CTRL_TRIG_TIMEOUT_EN
    begin
      int waits = 0, runs = 0;
      cmd_valid = 1'b1; cmd_op = OP_ARM;
      @(negedge clk);
      cmd_op = OP_START; cfg_duration = 32'd5; cfg_use_trigger = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 400 && state_o != ST_IDLE; c++) begin
        if (state_o == ST_WAIT_TRIG) waits++;
        if (ts_run) runs++;
        @(negedge clk);
      end
      check("tmo state", 64'(state_o), 64'd0);
      check("tmo pulse", {63'd0, timeout_err}, 64'd1);
      check("tmo wait cycles", 64'(waits), 64'd100);
      check("tmo no run", 64'(runs), 64'd0);
      @(negedge clk);
      check("tmo single", {63'd0, timeout_err}, 64'd0);
    end
`endif

    // Reset during an open-ended run: ts_run drops, no done, capture cleared.
    cmd_valid = 1'b1; cmd_op = OP_ARM;
    @(negedge clk);
    cmd_op = OP_START; cfg_duration = 32'd0; cfg_use_trigger = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst running", {63'd0, ts_run}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst ts_run", {63'd0, ts_run}, 64'd0);
    check("midrst state", 64'(state_o), 64'd0);
    begin
      int dones = 0;
      repeat (4) begin if (done) dones++; @(negedge clk); end
      check("midrst no done", 64'(dones), 64'd0);
    end
    check("midrst stop_ts", stop_timestamp, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timestamp_run_controller.md
Name: timestamp_run_controller

Overview:
Sequences the 64-bit timestamp generator for one acquisition window: clear, arm, start (on command or external trigger), fixed-length or open-ended run, stop. Drives the generator's run and clear inputs and captures the final timestamp. Sits between the host register/command interface and the timestamp generator in the photon-counting datapath.

Parameters:
DUR_W, 32, width of cfg_duration (run length in clk cycles)
TS_W, 64, timestamp width
TRIG_TIMEOUT, 1000000, WAIT_TRIG timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=ARM, 1=START, 2=STOP, 3=ABORT
cfg_duration  in  DUR_W  run length in cycles; 0 = run until STOP; sampled on START acceptance
cfg_use_trigger  in  1  1 = START waits for trigger_in; sampled on START acceptance
trigger_in  in  1  external trigger, already synchronised to clk, level-sensitive
timestamp_in  in  TS_W  generator output
ts_run  out  1  generator run enable (registered)
ts_clear  out  1  one-cycle generator clear pulse (registered)
stop_timestamp  out  TS_W  timestamp captured at window end
done  out  1  one-cycle pulse, stop_timestamp valid
cmd_err  out  1  one-cycle pulse on illegal command
state_o  out  3  current state encoding
timeout_err  out  1  one-cycle pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; ts_run=0, ts_clear=0, done=0, cmd_err=0, timeout_err=0, stop_timestamp=0, cmd_ready=1. Takes effect mid-run: ts_run drops the cycle after reset is sampled; no done pulse.
- States: IDLE=0, ARMED=1, WAIT_TRIG=2, RUNNING=3, DONE=4.
- cmd_ready=1 in every state except DONE. Commands take effect the cycle after acceptance.
- IDLE: ARM -> ts_clear=1 for one cycle, go to ARMED. START or STOP -> cmd_err, stay in IDLE.
- ARMED: START with cfg_use_trigger=0 -> RUNNING. START with cfg_use_trigger=1 -> WAIT_TRIG. ARM -> re-pulse ts_clear, stay in ARMED. STOP -> cmd_err.
- WAIT_TRIG: trigger_in=1 -> RUNNING. STOP -> cmd_err.
- RUNNING: ts_run=1 for the whole state. Internal run counter starts at 0 on entry and increments each cycle. If duration D != 0, leave after exactly D cycles of ts_run=1. STOP -> leave next cycle. Both conditions in the same cycle -> one transition. START/ARM -> cmd_err.
- DONE (one cycle): ts_run=0; latch timestamp_in into stop_timestamp; done=1; go to IDLE. Generator latency is 1 cycle, so after a clear, stop_timestamp == number of ts_run-high cycles.
- ABORT in any state except DONE -> IDLE next cycle, ts_run=0, no done, stop_timestamp unchanged.
- Same-cycle priority: reset > ABORT > STOP > duration expiry > trigger.
- Run counter is DUR_W bits. D=0 never expires and the counter saturates at its maximum, never wrapping.

Optional Feature:
Macro TS_RUN_CTRL_TRIG_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_TRIG. After TRIG_TIMEOUT cycles without a trigger, go to IDLE and pulse timeout_err. A trigger in the same cycle as the timeout wins.
- Undefined: WAIT_TRIG waits indefinitely; timeout_err is tied to 0; no counter logic.

Decomposition:
- Package ts_ctrl_pkg: state encodings, cmd_op constants (OP_ARM, OP_START, OP_STOP, OP_ABORT), default widths.
- Sub-module ts_duration_counter: load/enable/saturating counter with an expiry flag. Instantiated for the run length and, with the optional feature, for the trigger timeout.

Test Plan:
- Reset, then ARM, then START with cfg_duration=50, cfg_use_trigger=0 -> ts_clear pulses once; ts_run high exactly 50 cycles; done pulses; stop_timestamp=50.
- START with cfg_use_trigger=1, trigger_in raised 20 cycles later, cfg_duration=10 -> ts_run rises the cycle after the trigger; stop_timestamp=10.
- cfg_duration=0, STOP issued after 37 run cycles -> stop_timestamp=37; single done pulse.
- ABORT at run cycle 5 of 50 -> ts_run low next cycle; no done; stop_timestamp keeps its previous value. START while IDLE -> cmd_err; state_o stays 0.
- Duration expiry and STOP in the same cycle (D=8, STOP at cycle 8) -> exactly one done pulse; stop_timestamp=8.
- With TS_RUN_CTRL_TRIG_TIMEOUT_EN and TRIG_TIMEOUT=100, no trigger -> timeout_err pulses at cycle 100; state returns to IDLE; ts_run never asserted.
